// File: rtl/vga_stream_tx.sv
// VGA timing generator that drains a ready/valid 24-bit pixel stream into HS/VS/DE/RGB.
// Optional colour-bar generator (adds the Pattern port) enabled by `define VGA_STREAM_TX_PATTERN_EN.
module vga_stream_tx #(
   parameter int          Width     = 800,
   parameter int          FrontH    = 40,
   parameter int          PulseH    = 128,
   parameter int          BackH     = 88,
   parameter int          Height    = 600,
   parameter int          FrontV    = 1,
   parameter int          PulseV    = 4,
   parameter int          BackV     = 23,
   parameter logic [23:0] FillColor = 24'h000000
) (
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic        Enable,
   input  logic [23:0] Video,
   input  logic        VideoSOF,
   input  logic        VideoValid,
`ifdef VGA_STREAM_TX_PATTERN_EN
   input  logic        Pattern,
`endif
   output logic        VideoReady,
   output logic        VGA_HSOUT,
   output logic        VGA_VSOUT,
   output logic        VGA_DE,
   output logic [7:0]  VGA_RED,
   output logic [7:0]  VGA_GREEN,
   output logic [7:0]  VGA_BLUE,
   output logic        FrameStart,
   output logic [15:0] UnderflowCount,
   output logic        Misalign
);
   localparam int HTotal = PulseH + BackH + Width + FrontH;
   localparam int VTotal = PulseV + BackV + Height + FrontV;
   localparam int HW     = (HTotal > 1) ? $clog2(HTotal) : 1;
   localparam int VW     = (VTotal > 1) ? $clog2(VTotal) : 1;

   localparam logic [HW-1:0] H_LAST      = HW'(HTotal - 1);
   localparam logic [HW-1:0] H_PULSE     = HW'(PulseH);
   localparam logic [HW-1:0] H_ACT_FIRST = HW'(PulseH + BackH);
   localparam logic [HW-1:0] H_ACT_LAST  = HW'(PulseH + BackH + Width - 1);
   localparam logic [VW-1:0] V_LAST      = VW'(VTotal - 1);
   localparam logic [VW-1:0] V_PULSE     = VW'(PulseV);
   localparam logic [VW-1:0] V_ACT_FIRST = VW'(PulseV + BackV);
   localparam logic [VW-1:0] V_ACT_LAST  = VW'(PulseV + BackV + Height - 1);

   typedef enum logic [1:0] {
      IDLE,
      ALIGN,
      RUN
   } state_e;

   state_e        state_q, state_d;
   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic          hs_q, hs_d;
   logic          vs_q, vs_d;
   logic          de_q, de_d;
   logic          fs_q, fs_d;
   logic [23:0]   rgb_q, rgb_d;
   logic [15:0]   underflow_q, underflow_d;
   logic          misalign_q, misalign_d;

   logic          hs, vs, active, first;
   logic          video_ready;
   logic          pattern_on;
   logic [23:0]   bar_rgb;

   always_comb begin
      hs     = (h_q < H_PULSE);
      vs     = (v_q < V_PULSE);
      active = (h_q >= H_ACT_FIRST) && (h_q <= H_ACT_LAST) &&
               (v_q >= V_ACT_FIRST) && (v_q <= V_ACT_LAST);
      first  = (h_q == H_ACT_FIRST) && (v_q == V_ACT_FIRST);
   end

`ifdef VGA_STREAM_TX_PATTERN_EN
   logic [HW-1:0] h_off;
   logic [2:0]    bar_idx;
   logic [2:0]    bar_on;

   assign pattern_on = Pattern;
   assign h_off      = h_q - H_ACT_FIRST;
   assign bar_idx    = 3'((32'(h_off) * 32'd8) / 32'(Width));
   // Bars run white..black: R is off for bars 2,3,6,7; G off for 4..7; B off for odd bars.
   assign bar_on     = {~bar_idx[1], ~bar_idx[2], ~bar_idx[0]};

   for (genvar gi = 0; gi < 3; gi++) begin : g_bar
      assign bar_rgb[gi*8 +: 8] = {8{bar_on[gi]}};
   end
`else
   assign pattern_on = 1'b0;
   assign bar_rgb    = 24'h000000;
`endif

   always_comb begin
      state_d     = state_q;
      h_d         = h_q;
      v_d         = v_q;
      hs_d        = 1'b0;
      vs_d        = 1'b0;
      de_d        = 1'b0;
      fs_d        = 1'b0;
      rgb_d       = 24'h000000;
      underflow_d = underflow_q;
      misalign_d  = misalign_q;
      video_ready = 1'b0;

      if (!Enable) begin
         state_d = IDLE;
         h_d     = '0;
         v_d     = '0;
      end else begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
         end else begin
            h_d = h_q + 1'b1;
         end

         hs_d  = hs;
         vs_d  = vs;
         de_d  = active;
         fs_d  = (h_q == '0) && (v_q == '0);
         rgb_d = active ? FillColor : 24'h000000;

         if (pattern_on) begin
            // Timing keeps running; the stream and error tracking are frozen.
            if (active) begin
               rgb_d = bar_rgb;
            end
            if (state_q == IDLE) begin
               state_d = ALIGN;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  state_d = ALIGN;
               end
               ALIGN: begin
                  // Non-SOF pixels are flushed; an SOF waits at the head for `first`.
                  if (first && VideoValid && VideoSOF) begin
                     video_ready = 1'b1;
                     rgb_d       = Video;
                     state_d     = RUN;
                  end else begin
                     video_ready = VideoValid & ~VideoSOF;
                  end
               end
               RUN: begin
                  if (active) begin
                     if (!VideoValid) begin
                        if (underflow_q != 16'hFFFF) begin
                           underflow_d = underflow_q + 16'd1;
                        end
                     end else if (VideoSOF != first) begin
                        misalign_d = 1'b1;
                        state_d    = ALIGN;
                     end else begin
                        video_ready = 1'b1;
                        rgb_d       = Video;
                     end
                  end
               end
               default: begin
                  state_d = IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         h_q         <= '0;
         v_q         <= '0;
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         de_q        <= 1'b0;
         fs_q        <= 1'b0;
         rgb_q       <= 24'h000000;
         underflow_q <= 16'h0000;
         misalign_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         h_q         <= h_d;
         v_q         <= v_d;
         hs_q        <= hs_d;
         vs_q        <= vs_d;
         de_q        <= de_d;
         fs_q        <= fs_d;
         rgb_q       <= rgb_d;
         underflow_q <= underflow_d;
         misalign_q  <= misalign_d;
      end
   end

   assign VideoReady     = video_ready;
   assign VGA_HSOUT      = hs_q;
   assign VGA_VSOUT      = vs_q;
   assign VGA_DE         = de_q;
   assign VGA_RED        = rgb_q[23:16];
   assign VGA_GREEN      = rgb_q[15:8];
   assign VGA_BLUE       = rgb_q[7:0];
   assign FrameStart     = fs_q;
   assign UnderflowCount = underflow_q;
   assign Misalign       = misalign_q;

endmodule

// File: tb/tb_vga_stream_tx.sv
// Scoreboard bench for vga_stream_tx: a frame-arithmetic reference model predicts every cycle,
// a negedge monitor compares VideoReady and the registered video outputs against its queues.
module tb_vga_stream_tx;
   localparam int W  = 8;
   localparam int FH = 2;
   localparam int PH = 3;
   localparam int BH = 2;
   localparam int H  = 4;
   localparam int FV = 1;
   localparam int PV = 2;
   localparam int BV = 1;
   localparam int HT = PH + BH + W + FH;
   localparam int VT = PV + BV + H + FV;
   localparam int FR = HT * VT;
   localparam logic [23:0] FILL = 24'h5A3C11;

   localparam int M_IDLE  = 0;
   localparam int M_ALIGN = 1;
   localparam int M_RUN   = 2;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic        fs;
      logic [23:0] rgb;
      logic [15:0] uf;
      logic        mis;
   } exp_t;

   typedef struct packed {
      logic        sof;
      logic [23:0] d;
   } px_t;

   logic        Clock;
   logic        Reset_n;
   logic        Enable;
   logic [23:0] Video;
   logic        VideoSOF;
   logic        VideoValid;
`ifdef VGA_STREAM_TX_PATTERN_EN
   logic        Pattern;
`endif
   logic        VideoReady;
   logic        VGA_HSOUT;
   logic        VGA_VSOUT;
   logic        VGA_DE;
   logic [7:0]  VGA_RED;
   logic [7:0]  VGA_GREEN;
   logic [7:0]  VGA_BLUE;
   logic        FrameStart;
   logic [15:0] UnderflowCount;
   logic        Misalign;

   vga_stream_tx #(
      .Width(W), .FrontH(FH), .PulseH(PH), .BackH(BH),
      .Height(H), .FrontV(FV), .PulseV(PV), .BackV(BV),
      .FillColor(FILL)
   ) dut (
      .Clock(Clock),
      .Reset_n(Reset_n),
      .Enable(Enable),
      .Video(Video),
      .VideoSOF(VideoSOF),
      .VideoValid(VideoValid),
`ifdef VGA_STREAM_TX_PATTERN_EN
      .Pattern(Pattern),
`endif
      .VideoReady(VideoReady),
      .VGA_HSOUT(VGA_HSOUT),
      .VGA_VSOUT(VGA_VSOUT),
      .VGA_DE(VGA_DE),
      .VGA_RED(VGA_RED),
      .VGA_GREEN(VGA_GREEN),
      .VGA_BLUE(VGA_BLUE),
      .FrameStart(FrameStart),
      .UnderflowCount(UnderflowCount),
      .Misalign(Misalign)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   bit   mon_en = 0;
   bit   feed   = 0;
   bit   inject = 0;
   bit   rdy_q[$];
   exp_t out_q[$];
   px_t  src[$];

   // Reference model state: cycles since enable, mode, error counters.
   int m_n    = 0;
   int m_mode = M_IDLE;
   int m_uf   = 0;
   bit m_mis  = 0;

   function automatic logic [23:0] bar_color(input int idx);
      case (idx)
         0:       return 24'hFFFFFF;
         1:       return 24'hFFFF00;
         2:       return 24'h00FFFF;
         3:       return 24'h00FF00;
         4:       return 24'hFF00FF;
         5:       return 24'hFF0000;
         6:       return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   function automatic bit active_at(input int n);
      int h, v;
      h = n % HT;
      v = (n / HT) % VT;
      return (h >= PH + BH) && (h < PH + BH + W) && (v >= PV + BV) && (v < PV + BV + H);
   endfunction

   task automatic model(input bit en, input bit vld, input bit sof, input logic [23:0] d,
                        input bit pat, output bit rdy, output exp_t o);
      int h, v;
      bit act, first;
      rdy = 0;
      o   = '0;
      if (!en) begin
         m_mode = M_IDLE;
         m_n    = 0;
      end else begin
         h     = m_n % HT;
         v     = (m_n / HT) % VT;
         act   = active_at(m_n);
         first = (h == PH + BH) && (v == PV + BV);
         o.hs  = (h < PH);
         o.vs  = (v < PV);
         o.de  = act;
         o.fs  = (m_n % FR) == 0;
         o.rgb = act ? FILL : 24'h0;
         if (pat) begin
            if (act) o.rgb = bar_color((h - (PH + BH)) * 8 / W);
            if (m_mode == M_IDLE) m_mode = M_ALIGN;
         end else if (m_mode == M_IDLE) begin
            m_mode = M_ALIGN;
         end else if (m_mode == M_ALIGN) begin
            if (first && vld && sof) begin
               rdy    = 1;
               o.rgb  = d;
               m_mode = M_RUN;
            end else begin
               rdy = vld && !sof;
            end
         end else if (act) begin
            if (!vld) begin
               if (m_uf < 65535) m_uf = m_uf + 1;
            end else if (sof != first) begin
               m_mis  = 1;
               m_mode = M_ALIGN;
            end else begin
               rdy   = 1;
               o.rgb = d;
            end
         end
         m_n = m_n + 1;
      end
      o.uf  = 16'(m_uf);
      o.mis = m_mis;
   endtask

   task automatic push_frame(input int extra_sof);
      px_t p;
      for (int k = 0; k < W * H; k++) begin
         p.sof = (k == 0) || (k == extra_sof);
         p.d   = 24'($urandom);
         src.push_back(p);
      end
   endtask

   task automatic step(input bit en, input bit want_valid, input bit pat);
      bit   rdy;
      exp_t o;
      @(posedge Clock);
      #2;
      if (feed && src.size() < W * H) begin
         push_frame(inject ? 5 : -1);
         inject = 0;
      end
      Enable = en;
`ifdef VGA_STREAM_TX_PATTERN_EN
      Pattern = pat;
`endif
      if (want_valid && src.size() > 0) begin
         VideoValid = 1;
         Video      = src[0].d;
         VideoSOF   = src[0].sof;
      end else begin
         VideoValid = 0;
         Video      = 24'($urandom);
         VideoSOF   = 1'($urandom);
      end
      model(en, VideoValid, VideoSOF, Video, pat, rdy, o);
      if (rdy) void'(src.pop_front());
      rdy_q.push_back(rdy);
      out_q.push_back(o);
      mon_en = 1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   exp_t mon_e;
   exp_t mon_got;
   bit   mon_r;

   always @(negedge Clock) begin
      if (mon_en) begin
         cyc++;
         if (rdy_q.size() == 0 || out_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_empty cyc=%0d got=empty expected=entry", cyc);
         end else begin
            mon_r   = rdy_q.pop_front();
            mon_e   = out_q.pop_front();
            mon_got = {VGA_HSOUT, VGA_VSOUT, VGA_DE, FrameStart, VGA_RED, VGA_GREEN, VGA_BLUE,
                       UnderflowCount, Misalign};
            tests++;
            if (mon_got !== mon_e) begin
               fails++;
               $display("FAIL video_out cyc=%0d got hs%b vs%b de%b fs%b rgb=%h uf=%0d mis%b expected hs%b vs%b de%b fs%b rgb=%h uf=%0d mis%b",
                        cyc, mon_got.hs, mon_got.vs, mon_got.de, mon_got.fs, mon_got.rgb, mon_got.uf, mon_got.mis,
                        mon_e.hs, mon_e.vs, mon_e.de, mon_e.fs, mon_e.rgb, mon_e.uf, mon_e.mis);
            end
            tests++;
            if (VideoReady !== mon_r) begin
               fails++;
               $display("FAIL video_ready cyc=%0d got=%b expected=%b", cyc, VideoReady, mon_r);
            end
         end
      end
   end

   initial begin
      int drops;
      bit v;
      Reset_n    = 0;
      Enable     = 0;
      Video      = '0;
      VideoSOF   = 0;
      VideoValid = 0;
`ifdef VGA_STREAM_TX_PATTERN_EN
      Pattern    = 0;
`endif
      repeat (2) @(posedge Clock);
      #1;
      chk("reset_video", {VGA_HSOUT, VGA_VSOUT, VGA_DE, FrameStart, VGA_RED, VGA_GREEN, VGA_BLUE}, 0);
      chk("reset_underflow", UnderflowCount, 0);
      chk("reset_misalign", Misalign, 0);
      chk("reset_ready", VideoReady, 0);
      @(posedge Clock);
      #2;
      Reset_n = 1;
      out_q.push_back('0);

      repeat (3) step(0, 0, 0);
      // Timing only, no stream: stays in ALIGN with fill in the active window.
      repeat (2 * FR) step(1, 0, 0);

      // Continuous aligned stream.
      feed = 1;
      repeat (3 * FR) step(1, 1, 0);
      chk("clean_misalign", Misalign, 0);
      chk("clean_underflow", UnderflowCount, 0);

      // A frame carrying a second SOF at pixel 5.
      inject = 1;
      repeat (5 * FR) step(1, 1, 0);
      chk("sof_misalign", Misalign, 1);
      chk("sof_underflow", UnderflowCount, 0);

      // Drop valid on the first three active cycles of one frame.
      drops = 0;
      for (int i = 0; i < FR; i++) begin
         v = !(active_at(m_n) && drops < 3);
         if (!v) drops++;
         step(1, v, 0);
      end
      chk("underflow_three", UnderflowCount, 3);

      // Randomised valid gaps.
      for (int i = 0; i < 3 * FR; i++) step(1, $urandom_range(0, 3) != 0, 0);

      // Enable dropped mid-line for 10 cycles, then restart.
      for (int i = 0; i < HT && (m_n % HT) != 7; i++) step(1, 1, 0);
      repeat (10) step(0, 1, 0);
      repeat (3 * FR) step(1, 1, 0);

`ifdef VGA_STREAM_TX_PATTERN_EN
      repeat (FR) step(1, 1, 1);
      repeat (FR) step(1, 1, 0);
`endif

      @(posedge Clock);
      #1;
      mon_en = 0;
      Enable     = 1;
      VideoValid = 1;
      @(posedge Clock);
      #3;
      Reset_n = 0;
      #1;
      chk("async_reset_video", {VGA_HSOUT, VGA_VSOUT, VGA_DE, FrameStart, VGA_RED, VGA_GREEN, VGA_BLUE}, 0);
      chk("async_reset_underflow", UnderflowCount, 0);
      chk("async_reset_misalign", Misalign, 0);
      chk("async_reset_ready", VideoReady, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_stream_tx.md
Name: vga_stream_tx

Overview:
- Transmit-side counterpart of the VGA capture path.
- Generates VGA-style timing (HSOUT/VSOUT/DE) and drives 24-bit RGB pixels pulled from a ready/valid pixel stream.
- Line/frame ordering matches the capture side: sync pulse, back porch, active, front porch.
- Feeds board-level test loopback or an external encoder, so captured frames can be regenerated in-system.

Parameters:
- Width, 800, active pixels per line
- FrontH, 40, horizontal front porch (cycles)
- PulseH, 128, hsync pulse width
- BackH, 88, horizontal back porch
- Height, 600, active lines per frame
- FrontV, 1, vertical front porch (lines)
- PulseV, 4, vsync pulse width (lines)
- BackV, 23, vertical back porch (lines)
- FillColor, 24'h000000, RGB driven on underflow or misalignment

Ports:
- Clock  in  1  pixel clock; all logic on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Enable  in  1  1 = run timing; 0 = idle
- Video  in  24  {R,G,B} pixel
- VideoSOF  in  1  marks first pixel of a frame; qualified by VideoValid
- VideoValid  in  1  stream valid
- VideoReady  out  1  stream ready; transfer when VideoValid & VideoReady
- VGA_HSOUT  out  1  hsync, active high
- VGA_VSOUT  out  1  vsync, active high
- VGA_DE  out  1  active-video strobe
- VGA_RED / VGA_GREEN / VGA_BLUE  out  8 each  pixel data
- FrameStart  out  1  one-cycle pulse coinciding with first VGA_HSOUT of a frame
- UnderflowCount  out  16  saturating count of active pixels with no valid data
- Misalign  out  1  sticky; set on any SOF/position mismatch

Behaviour:
- HTotal = PulseH+BackH+Width+FrontH; VTotal = PulseV+BackV+Height+FrontV.
- Counters:
  - h counts 0..HTotal-1, wraps to 0 and increments v.
  - v counts 0..VTotal-1, wraps to 0.
  - Counter widths: clog2 of the totals.
- Region decode:
  - hs = h < PulseH.
  - vs = v < PulseV.
  - active = h in [PulseH+BackH, PulseH+BackH+Width) AND v in [PulseV+BackV, PulseV+BackV+Height).
  - first = h == PulseH+BackH AND v == PulseV+BackV.
- Reset (Reset_n low, asynchronous): h=v=0, state IDLE; all outputs 0; UnderflowCount=0; Misalign=0.
- Output latency: all VGA_* outputs and FrameStart are registered, 1 cycle after the counter value that produced them.
- States:
  - IDLE:
    - Counters held at 0; VideoReady=0; outputs 0.
    - Enable=1 -> ALIGN; counting starts the same cycle, so h=0,v=0 appears on outputs next cycle.
  - ALIGN:
    - VideoReady = VideoValid & ~VideoSOF, so non-SOF pixels are discarded.
    - A valid SOF pixel is held at the head.
    - At cycle `first` with a held SOF: consume it (VideoReady=1) and go to RUN.
    - Otherwise active pixels drive FillColor and do not count as underflow.
  - RUN:
    - VideoReady = active.
    - Active cycle with VideoValid=0: drive FillColor; UnderflowCount += 1, saturating at 16'hFFFF.
    - Valid pixel with VideoSOF=1 at a non-first active position: not consumed; Misalign=1; go to ALIGN; FillColor for the rest of the frame.
    - At `first`, valid pixel with VideoSOF=0: same handling (Misalign, ALIGN, not consumed).
  - Any state, Enable=0: return to IDLE immediately. Counters are zeroed; UnderflowCount and Misalign are kept.
- Blanking: RGB = 0 whenever not active.
- Stream rule: VideoReady never asserts outside active, except ALIGN's discard of non-SOF pixels.

Optional Feature:
- Macro: VGA_STREAM_TX_PATTERN_EN.
- Defined:
  - Adds input port Pattern (1 bit).
  - Pattern=1: RGB in active area = 8 equal-width vertical colour bars. Bar index = (h-(PulseH+BackH))*8/Width. Bars in order white, yellow, cyan, green, magenta, red, blue, black, each 8'hFF/8'h00 per component.
  - Pattern=1 forces VideoReady=0 and freezes UnderflowCount and Misalign; timing is unchanged.
- Undefined: no Pattern port; behaviour as above.

Test Plan:
Test parameters for all scenarios: Width=8, FrontH=2, PulseH=3, BackH=2, Height=4, FrontV=1, PulseV=2, BackV=1, so HTotal=15, VTotal=8, frame=120 cycles.
- Reset + Enable, no stream -> VGA_HSOUT high for 3 of every 15 cycles; VGA_VSOUT high for 30 cycles per 120; VGA_DE high 32 cycles per frame; FrameStart every 120 cycles; RGB=0; UnderflowCount=0 (ALIGN).
- Continuous stream of 32 pixels 0..31, SOF on pixel 0 -> pixel k appears on RGB at active index k, 1 cycle after its handshake; UnderflowCount=0; Misalign=0; next frame repeats.
- RUN, VideoValid dropped for 3 active cycles -> FillColor on those 3 pixels; UnderflowCount=3; later pixels shift by 3 positions.
- SOF presented at active pixel 5 while in RUN -> Misalign=1; FillColor for active pixels 5..31; SOF pixel consumed at next frame's first pixel.
- Enable deasserted mid-line, re-asserted after 10 cycles -> outputs 0 while low; timing restarts at h=0,v=0; UnderflowCount retained. Reset_n pulsed mid-frame -> all outputs 0 asynchronously.
- VGA_STREAM_TX_PATTERN_EN with Pattern=1 -> active pixel 0 = 24'hFFFFFF, pixel 1 = 24'hFFFF00, pixel 7 = 24'h000000; VideoReady=0.
